// File: rtl/tinker_fetch_queue_if.sv
// Memory-side and decoder-side handshake bundle of the instruction fetch queue.
interface tinker_fetch_queue_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;

  // Fetch queue side: issues reads, presents queued instructions.
  modport master (
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, inst_ready
  );

  // Memory / decoder side.
  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    output mem_gnt, mem_rvalid, mem_rdata, inst_ready
  );
endinterface

// File: rtl/tinker_fetch_queue.sv
// Instruction prefetch queue: sequential PC generation, single outstanding
// memory read, FIFO of {pc, word} pairs consumed by the decoder.
module tinker_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic                         clk,
  input  logic                         reset,
  tinker_fetch_queue_if.master         bus,
  input  logic                         redirect,
  input  logic [63:0]                  redirect_pc,
  input  logic                         halt,
  output logic                         halted,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         protocol_err
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } entry_t;

  // S_BUSY: one read in flight; S_STALE: in-flight read must be dropped.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_STALE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [63:0]        fetch_pc;
  logic [63:0]        req_pc;
  entry_t             fifo [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;

  logic mem_req_c, grant_c, push_c, pop_c, perr_c;

  // Read-request state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Request gating, response disposition and next read state.
  always_comb begin
    state_nxt = state;
    mem_req_c = 1'b0;
    grant_c   = 1'b0;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    perr_c    = 1'b0;

    // Idle implies nothing outstanding, so the slot check reduces to occupancy.
    mem_req_c = (state == S_IDLE) && !halted && !halt && !redirect &&
                (occupancy < OCC_W'(DEPTH));
    grant_c   = mem_req_c && bus.mem_gnt;
    pop_c     = (occupancy != '0) && bus.inst_ready && !redirect;

    case (state)
      S_IDLE: begin
        perr_c = bus.mem_rvalid;
        if (grant_c) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (bus.mem_rvalid) begin
          push_c    = !redirect;
          state_nxt = S_IDLE;
        end else if (redirect) begin
          state_nxt = S_STALE;
        end
      end
      S_STALE: begin
        if (bus.mem_rvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch PC, FIFO storage/pointers and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      req_pc       <= '0;
      fifo         <= '{default: '0};
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      occupancy    <= '0;
      halted       <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (halt)   halted       <= 1'b1;
      if (perr_c) protocol_err <= 1'b1;

      if (redirect) begin
        fetch_pc <= {redirect_pc[63:2], 2'b00};
      end else if (grant_c) begin
        fetch_pc <= fetch_pc + 64'd4;
        req_pc   <= fetch_pc;
      end

      if (push_c) begin
        fifo[wr_ptr].pc   <= req_pc;
        fifo[wr_ptr].word <= bus.mem_rdata;
      end

      if (redirect) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        occupancy <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push_c, pop_c})
          2'b10:   occupancy <= occupancy + OCC_W'(1);
          2'b01:   occupancy <= occupancy - OCC_W'(1);
          default: occupancy <= occupancy;
        endcase
      end
    end
  end

  // Outputs: request is combinational, head comes straight from storage.
  assign bus.mem_req    = mem_req_c;
  assign bus.mem_addr   = fetch_pc;
  assign bus.inst_valid = (occupancy != '0);
  assign bus.inst_data  = fifo[rd_ptr].word;
  assign bus.inst_pc    = fifo[rd_ptr].pc;

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Self-checking bench for tinker_fetch_queue: table-driven streaming and
// backpressure vectors plus hand sequences for redirect, halt and error cases.
module tb_tinker_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h2000;
  localparam int unsigned OCC_W    = $clog2(DEPTH + 1);

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rdy;
    bit          exp_req;
    logic [63:0] exp_addr;
    int          exp_occ;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             redirect;
  logic [63:0]      redirect_pc;
  logic             halt;
  logic             halted;
  logic [OCC_W-1:0] occupancy;
  logic             protocol_err;

  tinker_fetch_queue_if bus();

  tinker_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .halted       (halted),
    .occupancy    (occupancy),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state; sb is the expected FIFO contents (scoreboard).
  logic [63:0] m_pc;
  bit          m_out, m_stale, m_halted, m_perr;
  ent_t        sb[$];
  // Memory responder state.
  bit          rsp_pend;
  logic [63:0] rsp_pc;
  logic [31:0] rsp_data;
  int          data_ctr;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.inst_ready = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    m_pc     = RESET_PC;
    m_out    = 1'b0;
    m_stale  = 1'b0;
    m_halted = 1'b0;
    m_perr   = 1'b0;
    sb.delete();
    rsp_pend = 1'b0;
    rsp_pc   = '0;
    rsp_data = '0;
    data_ctr = 0;
  endtask

  // One clock: drive at negedge, check against the model, update the model.
  // hd holds back a pending response; sp pulses a spurious rvalid.
  task automatic cyc(input bit g, input bit r, input bit rd, input logic [63:0] rp,
                     input bit h, input bit hd, input bit sp,
                     output bit s_req, output logic [63:0] s_addr, output int s_occ);
    bit   rv, deliver, exp_req, grant, pop;
    ent_t e;
    deliver        = rsp_pend && !hd;
    rv             = deliver || sp;
    bus.mem_gnt    = g;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = deliver ? rsp_data : 32'hDEAD_BEEF;
    bus.inst_ready = r;
    redirect       = rd;
    redirect_pc    = rp;
    halt           = h;
    #1;
    s_req   = bus.mem_req;
    s_addr  = bus.mem_addr;
    s_occ   = int'(occupancy);
    exp_req = !m_out && !m_halted && !h && !rd && ((sb.size() + int'(m_out)) < int'(DEPTH));
    chk("mem_req", 64'(bus.mem_req), 64'(exp_req));
    if (exp_req) chk("mem_addr", bus.mem_addr, m_pc);
    chk("occupancy", 64'(occupancy), 64'(sb.size()));
    chk("inst_valid", 64'(bus.inst_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("inst_pc", bus.inst_pc, sb[0].pc);
      chk("inst_data", 64'(bus.inst_data), 64'(sb[0].data));
    end
    chk("halted", 64'(halted), 64'(m_halted));
    chk("protocol_err", 64'(protocol_err), 64'(m_perr));

    grant = exp_req && g;
    pop   = (sb.size() != 0) && r && !rd;
    if (pop) e = sb.pop_front();
    if (rv && !m_out) m_perr = 1'b1;
    if (rv && m_out) begin
      if (!m_stale && !rd) begin
        e.pc   = rsp_pc;
        e.data = rsp_data;
        sb.push_back(e);
      end
      m_out   = 1'b0;
      m_stale = 1'b0;
    end else if (rd && m_out) begin
      m_stale = 1'b1;
    end
    if (deliver) rsp_pend = 1'b0;
    if (grant) begin
      m_out    = 1'b1;
      rsp_pend = 1'b1;
      rsp_pc   = m_pc;
      data_ctr++;
      rsp_data = 32'hA000_0000 + 32'(data_ctr);
      m_pc     = m_pc + 64'd4;
    end
    if (rd) begin
      sb.delete();
      m_pc = {rp[63:2], 2'b00};
    end
    if (h) m_halted = 1'b1;
    @(negedge clk);
  endtask

  task automatic add(input bit rst, input bit g, input bit r, input bit req,
                     input logic [63:0] addr, input int occ);
    vec_t v;
    v.rst = rst; v.gnt = g; v.rdy = r; v.exp_req = req; v.exp_addr = addr; v.exp_occ = occ;
    tbl.push_back(v);
  endtask

  initial begin
    bit          s_req;
    logic [63:0] s_addr;
    int          s_occ;

    // Streaming fill: every grant answered next cycle, decoder always ready.
    add(1, 1, 1, 1, 64'h2000, 0);
    add(0, 1, 1, 0, 64'h0,    0);
    add(0, 1, 1, 1, 64'h2004, 1);
    add(0, 1, 1, 0, 64'h0,    0);
    add(0, 1, 1, 1, 64'h2008, 1);
    add(0, 1, 1, 0, 64'h0,    0);
    add(0, 1, 1, 1, 64'h200C, 1);
    add(0, 1, 1, 0, 64'h0,    0);
    // Backpressure: fill to DEPTH, one pop frees exactly one new request.
    add(1, 1, 0, 1, 64'h2000, 0);
    add(0, 1, 0, 0, 64'h0,    0);
    add(0, 1, 0, 1, 64'h2004, 1);
    add(0, 1, 0, 0, 64'h0,    1);
    add(0, 1, 0, 1, 64'h2008, 2);
    add(0, 1, 0, 0, 64'h0,    2);
    add(0, 1, 0, 1, 64'h200C, 3);
    add(0, 1, 0, 0, 64'h0,    3);
    add(0, 1, 0, 0, 64'h0,    4);
    add(0, 1, 0, 0, 64'h0,    4);
    add(0, 1, 1, 0, 64'h0,    4);
    add(0, 1, 0, 1, 64'h2010, 3);
    add(0, 1, 0, 0, 64'h0,    3);
    add(0, 1, 0, 0, 64'h0,    4);
    add(0, 1, 0, 0, 64'h0,    4);

    // Reset state.
    do_reset();
    #1;
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_inst_data", 64'(bus.inst_data), 64'd0);
    chk("rst_inst_pc", bus.inst_pc, 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd1);
    chk("rst_mem_addr", bus.mem_addr, RESET_PC);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_protocol_err", 64'(protocol_err), 64'd0);
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      cyc(tbl[i].gnt, tbl[i].rdy, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, s_req, s_addr, s_occ);
      chk($sformatf("vec%0d_req", i), 64'(s_req), 64'(tbl[i].exp_req));
      if (tbl[i].exp_req) chk($sformatf("vec%0d_addr", i), s_addr, tbl[i].exp_addr);
      chk($sformatf("vec%0d_occ", i), 64'(s_occ), 64'(tbl[i].exp_occ));
    end

    // Redirect with a read in flight: late response must be dropped.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    cyc(1, 0, 1, 64'h3002, 0, 1, 0, s_req, s_addr, s_occ);
    chk("redir_flush_occ", 64'(occupancy), 64'd0);
    cyc(1, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    chk("redir_late_req", 64'(s_req), 64'd0);
    chk("redir_late_drop_occ", 64'(occupancy), 64'd0);
    cyc(1, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    chk("redir_new_req", 64'(s_req), 64'd1);
    chk("redir_new_addr", s_addr, 64'h3000);
    cyc(0, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    chk("redir_first_valid", 64'(bus.inst_valid), 64'd1);
    chk("redir_first_pc", bus.inst_pc, 64'h3000);

    // Redirect, rvalid and pop all in one cycle.
    do_reset();
    cyc(1, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    cyc(0, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    cyc(1, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    cyc(0, 1, 1, 64'h4000, 0, 0, 0, s_req, s_addr, s_occ);
    chk("coinc_occ", 64'(occupancy), 64'd0);
    cyc(1, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    chk("coinc_req_not_stale", 64'(s_req), 64'd1);
    chk("coinc_addr", s_addr, 64'h4000);
    cyc(0, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    chk("coinc_accept_occ", 64'(occupancy), 64'd1);
    chk("coinc_accept_pc", bus.inst_pc, 64'h4000);

    // Halt with one read outstanding and two entries queued.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    cyc(1, 0, 0, 64'h0, 1, 1, 0, s_req, s_addr, s_occ);
    chk("halt_cycle_req", 64'(s_req), 64'd0);
    chk("halt_halted", 64'(halted), 64'd1);
    cyc(1, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    chk("halt_inflight_queued", 64'(occupancy), 64'd3);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    chk("halt_drained", 64'(occupancy), 64'd0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, (i == 10), 64'h5000, 0, 0, 0, s_req, s_addr, s_occ);
      chk($sformatf("halt_no_req%0d", i), 64'(s_req), 64'd0);
    end
    chk("halt_sticky", 64'(halted), 64'd1);

    // Spurious response with nothing outstanding.
    do_reset();
    cyc(0, 0, 0, 64'h0, 0, 0, 1, s_req, s_addr, s_occ);
    chk("perr_set", 64'(protocol_err), 64'd1);
    chk("perr_occ", 64'(occupancy), 64'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 64'h0, 0, 0, 0, s_req, s_addr, s_occ);
    chk("perr_sticky", 64'(protocol_err), 64'd1);
    do_reset();
    #1;
    chk("perr_cleared", 64'(protocol_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
